// File: rtl/debounce_pkg.sv
// Shared types and helpers for the push-button debouncer bank.
package debounce_pkg;

  // Per-channel event bundle consumed by the stopwatch control FSM.
  typedef struct packed {
    logic rise;
    logic fall;
    logic long_press;
    logic held;
  } ch_evt_t;

  // 64-bit intermediate so large CLK_FREQ * ms products do not overflow.
  function automatic int unsigned ms_to_cycles(input longint unsigned freq,
                                               input longint unsigned ms);
    longint unsigned cyc;
    cyc = (freq * ms) / 64'd1000;
    return 32'(cyc);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debouncer channel: 2-flop synchroniser, stability counter and, when
// DEBOUNCE_LONG_PRESS_EN is defined, a saturating hold counter.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned LONG_CYCLES   = 10
) (
  input  logic    clk,
  input  logic    reset_n,
  input  logic    b,
  output logic    result,
  output ch_evt_t evt
);

  localparam int unsigned CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;
  logic          rise_q;
  logic          fall_q;
  logic          long_q;
  logic          held_q;
  logic          accept_c;

  assign accept_c = (s2 != result) && (cnt == CNT_LAST);

  // Synchroniser and stability filter; any return to result drops the partial count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      cnt    <= '0;
      result <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      s1     <= b;
      s2     <= s1;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      if (s2 == result) begin
        cnt <= '0;
      end else if (accept_c) begin
        result <= s2;
        cnt    <= '0;
        rise_q <= s2;
        fall_q <= ~s2;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

`ifdef DEBOUNCE_LONG_PRESS_EN
  localparam int unsigned HW = $clog2(LONG_CYCLES + 1);
  localparam logic [HW-1:0] HCNT_MAX  = HW'(LONG_CYCLES);
  localparam logic [HW-1:0] HCNT_LAST = HW'(LONG_CYCLES - 1);

  logic [HW-1:0] hcnt;
  logic          long_hit_c;

  // A release accepted on the very edge the hold completes wins over the long press.
  assign long_hit_c = result && !accept_c && (hcnt == HCNT_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hcnt   <= '0;
      long_q <= 1'b0;
      held_q <= 1'b0;
    end else begin
      long_q <= long_hit_c;
      if (!result) begin
        hcnt <= '0;
      end else if (hcnt != HCNT_MAX) begin
        hcnt <= hcnt + HW'(1);
      end
      if (accept_c && result) begin
        held_q <= 1'b0;
      end else if (long_hit_c) begin
        held_q <= 1'b1;
      end
    end
  end
`else
  // Hold length only matters when the long-press logic is built.
  if (LONG_CYCLES == 0) begin : g_long_unused
  end

  assign long_q = 1'b0;
  assign held_q = 1'b0;
`endif

  assign evt = '{rise: rise_q, fall: fall_q, long_press: long_q, held: held_q};

endmodule

// File: rtl/debounce_bank.sv
// N-channel push-button debouncer bank with press/release pulses.
// Define DEBOUNCE_LONG_PRESS_EN to build long-press pulse and held level.
module debounce_bank
  import debounce_pkg::*;
#(
  parameter int unsigned     N_CH      = 4,
  parameter int unsigned     CLK_FREQ  = 25_000_000,
  parameter int unsigned     STABLE_MS = 10,
  parameter int unsigned     LONG_MS   = 1000,
  parameter logic [N_CH-1:0] INVERT    = '0
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [N_CH-1:0] button,
  output logic [N_CH-1:0] result,
  output logic [N_CH-1:0] rise_p,
  output logic [N_CH-1:0] fall_p,
  output logic [N_CH-1:0] long_p,
  output logic [N_CH-1:0] held
);

  localparam int unsigned STABLE_CYCLES = ms_to_cycles(64'(CLK_FREQ), 64'(STABLE_MS));
  localparam int unsigned LONG_CYCLES   = ms_to_cycles(64'(CLK_FREQ), 64'(LONG_MS));

  if (STABLE_CYCLES < 1) begin : g_bad_stable
    $error("debounce_bank: STABLE_CYCLES must be at least 1");
  end

`ifdef DEBOUNCE_LONG_PRESS_EN
  if (LONG_CYCLES < 1 || LONG_CYCLES <= STABLE_CYCLES) begin : g_bad_long
    $error("debounce_bank: LONG_CYCLES must be at least 1 and exceed STABLE_CYCLES");
  end
`endif

  // Move every channel into logical space (1 = pressed) before synchronising.
  logic [N_CH-1:0] b_c;
  assign b_c = button ^ INVERT;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    ch_evt_t evt;

    debounce_channel #(
      .STABLE_CYCLES(STABLE_CYCLES),
      .LONG_CYCLES  (LONG_CYCLES)
    ) u_ch (
      .clk    (clk),
      .reset_n(reset_n),
      .b      (b_c[i]),
      .result (result[i]),
      .evt    (evt)
    );

    assign rise_p[i] = evt.rise;
    assign fall_p[i] = evt.fall;
    assign long_p[i] = evt.long_press;
    assign held[i]   = evt.held;
  end

endmodule

// File: tb/tb_debounce_bank.sv
// Self-checking bench for debounce_bank: directed scenarios plus random
// stimulus compared every cycle against a sliding-window reference model.
module tb_debounce_bank;

  localparam int unsigned     N_CH          = 4;
  localparam int unsigned     CLK_FREQ      = 1000;
  localparam int unsigned     STABLE_MS     = 4;
  localparam int unsigned     LONG_MS       = 10;
  localparam int unsigned     STABLE_CYCLES = 4;
  localparam int unsigned     LONG_CYCLES   = 10;
  localparam logic [N_CH-1:0] INVERT        = 4'b1000;
`ifdef DEBOUNCE_LONG_PRESS_EN
  localparam bit LONG_EN = 1'b1;
`else
  localparam bit LONG_EN = 1'b0;
`endif
  localparam logic [N_CH-1:0] LMASK0 = LONG_EN ? 4'b0001 : 4'b0000;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [N_CH-1:0] button;
  logic [N_CH-1:0] result, rise_p, fall_p, long_p, held;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  debounce_bank #(
    .N_CH     (N_CH),
    .CLK_FREQ (CLK_FREQ),
    .STABLE_MS(STABLE_MS),
    .LONG_MS  (LONG_MS),
    .INVERT   (INVERT)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .button (button),
    .result (result),
    .rise_p (rise_p),
    .fall_p (fall_p),
    .long_p (long_p),
    .held   (held)
  );

  task automatic check(input string name, input logic [N_CH-1:0] got,
                       input logic [N_CH-1:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: a level is accepted once the last STABLE_CYCLES values
  // seen two edges late all disagree with the current result.
  logic [N_CH-1:0] m_res, m_rise, m_fall, m_long, m_held;
  bit              hist [N_CH][STABLE_CYCLES+1];
  int unsigned     age  [N_CH];

  task model_step();
    bit              all_diff;
    logic [N_CH-1:0] b;
    if (!reset_n) begin
      m_res = '0; m_rise = '0; m_fall = '0; m_long = '0; m_held = '0;
      for (int i = 0; i < N_CH; i++) begin
        age[i] = 0;
        for (int j = 0; j <= STABLE_CYCLES; j++) hist[i][j] = 1'b0;
      end
    end else begin
      b = button ^ INVERT;
      for (int i = 0; i < N_CH; i++) begin
        m_rise[i] = 1'b0;
        m_fall[i] = 1'b0;
        m_long[i] = 1'b0;
        all_diff = 1'b1;
        for (int j = 1; j <= STABLE_CYCLES; j++)
          if (hist[i][j] == m_res[i]) all_diff = 1'b0;
        if (all_diff) begin
          m_res[i] = ~m_res[i];
          if (m_res[i]) begin
            m_rise[i] = 1'b1;
            age[i] = 0;
          end else begin
            m_fall[i] = 1'b1;
            m_held[i] = 1'b0;
          end
        end else if (m_res[i] && LONG_EN && age[i] < LONG_CYCLES) begin
          age[i]++;
          if (age[i] == LONG_CYCLES) begin
            m_long[i] = 1'b1;
            m_held[i] = 1'b1;
          end
        end
        for (int j = STABLE_CYCLES; j >= 1; j--) hist[i][j] = hist[i][j-1];
        hist[i][0] = b[i];
      end
    end
  endtask

  always @(posedge clk or negedge reset_n) model_step();

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    check("cyc_result", result, m_res);
    check("cyc_rise_p", rise_p, m_rise);
    check("cyc_fall_p", fall_p, m_fall);
    check("cyc_long_p", long_p, m_long);
    check("cyc_held",   held,   m_held);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int unsigned p;
    reset_n = 1'b0;
    button  = 4'b1000;
    repeat (3) tick();
    check("rst_result", result, 4'b0000);
    check("rst_pulses", rise_p | fall_p | long_p | held, 4'b0000);
    reset_n = 1'b1;

    // Idle active-low channel 3 through reset release.
    repeat (10) tick();
    check("idle_ch3", result, 4'b0000);

    // Clean press on channel 0 with long-press timing.
    button[0] = 1'b1;
    repeat (5) tick();
    check("s1_pre", result, 4'b0000);
    tick();
    check("s1_rise", rise_p, 4'b0001);
    check("s1_res", result, 4'b0001);
    tick();
    check("s1_rise_once", rise_p, 4'b0000);
    repeat (8) tick();
    check("long_pre", long_p, 4'b0000);
    tick();
    check("long_at", long_p, LMASK0);
    check("held_at", held, LMASK0);
    tick();
    check("long_once", long_p, 4'b0000);
    repeat (23) tick();
    check("held_hold", held, LMASK0);
    button[0] = 1'b0;
    repeat (5) tick();
    check("held_pre_fall", held, LMASK0);
    tick();
    check("s1_fall", fall_p, 4'b0001);
    check("held_clr", held, 4'b0000);
    check("s1_res_low", result, 4'b0000);

    // Bouncing channel 1, 3-cycle toggles, then settle high.
    for (int k = 0; k < 4; k++) begin
      button[1] = (k % 2 == 0);
      repeat (3) tick();
    end
    check("s2_bounce", result | rise_p, 4'b0000);
    button[1] = 1'b1;
    repeat (5) tick();
    check("s2_pre", rise_p, 4'b0000);
    tick();
    check("s2_rise", rise_p, 4'b0010);
    button[1] = 1'b0;
    repeat (10) tick();

    // Simultaneous press on channels 0 and 2.
    button[0] = 1'b1;
    button[2] = 1'b1;
    repeat (6) tick();
    check("s3_rise", rise_p, 4'b0101);
    tick();
    check("s3_rise_once", rise_p, 4'b0000);
    button[0] = 1'b0;
    button[2] = 1'b0;
    repeat (10) tick();

    // Active-low channel 3 driven low.
    button[3] = 1'b0;
    repeat (6) tick();
    check("s4_rise", rise_p, 4'b1000);

    // Reset while channel 0 is mid-count and still pressed.
    repeat (10) tick();
    button[0] = 1'b1;
    repeat (4) tick();
    reset_n = 1'b0;
    #1;
    check("s6_rst_res", result, 4'b0000);
    check("s6_rst_out", rise_p | fall_p | long_p | held, 4'b0000);
    tick();
    reset_n = 1'b1;
    repeat (5) tick();
    check("s6_pre", rise_p, 4'b0000);
    tick();
    check("s6_rise", rise_p, 4'b1001);

    // Random phase alternating bouncy and calm stretches.
    for (int c = 0; c < 1500; c++) begin
      p = ((c / 150) % 2 == 1) ? 3 : 40;
      for (int i = 0; i < N_CH; i++)
        if ($urandom_range(p - 1) == 0) button[i] = ~button[i];
      if (c % 500 == 250) begin
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
      end
      tick();
    end
    repeat (20) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
